dbg_csr_bank: RTL

Parametrised debug CSR bank holding dcsr, dpc and a configurable number of dscratch registers, plus the hart's debug-mode state. Sits between the core pipeline, which supplies debug entry/resume events and the PC, and the Debug Module, which reaches the registers through a request/grant/response handshake with error reporting.

---
 rtl/dbg_csr_pkg.sv | 42 ++++
 rtl/dbg_dcsr_reg.sv | 45 ++++
 rtl/dbg_csr_bank.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dbg_csr_pkg.sv
// Shared definitions for the debug CSR bank: CSR numbers, dcsr write/read
// masks, dcsr cause encodings, FSM state enums and the dcsr field layout.
package dbg_csr_pkg;

  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;

  // ebreakm, ebreaks, ebreaku, stepie, stopcount, stoptime, step, prv
  localparam logic [31:0] DCSR_WMASK         = 32'h0000_BE07;
  // Writable fields plus the read-only xdebugver and cause fields
  localparam logic [31:0] DCSR_RMASK         = 32'hF000_BFC7;
  localparam logic [31:0] DCSR_RESET_DEFAULT = 32'h4000_0003;

  typedef enum logic [2:0] {
    CauseEbreak  = 3'd1,
    CauseTrigger = 3'd2,
    CauseHaltreq = 3'd3,
    CauseStep    = 3'd4
  } dcsr_cause_e;

  typedef enum logic [0:0] {ModeRun, ModeHalted} mode_e;
  typedef enum logic [0:0] {AccIdle, AccResp} acc_e;

  typedef struct packed {
    logic [3:0]  xdebugver;
    logic [11:0] zero_hi;
    logic        ebreakm;
    logic        zero_14;
    logic        ebreaks;
    logic        ebreaku;
    logic        stepie;
    logic        stopcount;
    logic        stoptime;
    logic [2:0]  cause;
    logic [2:0]  zero_lo;
    logic        step;
    logic [1:0]  prv;
  } dcsr_t;

endpackage

// File: rtl/dbg_dcsr_reg.sv
// dcsr register: masked DM writes and cause capture on debug entry.
// Ports: clk_i/reset_i (sync, active-high), capture_i + cause_i (entry),
// we_i + wdata_i (DM write), dcsr_o (full value), step_o, ebreakm_o.
module dbg_dcsr_reg
  import dbg_csr_pkg::*;
#(
  parameter logic [31:0] DCSR_RESET = DCSR_RESET_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        capture_i,
  input  logic [2:0]  cause_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] dcsr_o,
  output logic        step_o,
  output logic        ebreakm_o
);

  dcsr_t dcsr_q, dcsr_d;

  // capture_i (RUN only) and we_i (HALTED only) never coincide.
  always_comb begin
    dcsr_d = dcsr_q;
    if (capture_i) begin
      dcsr_d.cause = cause_i;
    end else if (we_i) begin
      dcsr_d = dcsr_t'((32'(dcsr_q) & ~DCSR_WMASK) | (wdata_i & DCSR_WMASK));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // Undefined bits are forced to zero so they always read as zero.
      dcsr_q <= dcsr_t'(DCSR_RESET & DCSR_RMASK);
    end else begin
      dcsr_q <= dcsr_d;
    end
  end

  assign dcsr_o    = 32'(dcsr_q);
  assign step_o    = dcsr_q.step;
  assign ebreakm_o = dcsr_q.ebreakm;

endmodule

// File: rtl/dbg_csr_bank.sv
// Debug CSR bank: dcsr, dpc, dscratch0..NUM_DSCRATCH-1 and the hart debug
// mode, with a request/grant/response port for the Debug Module.
// Core side: entry_i/cause_i/pc_i, resume_i -> debug_mode_o, dpc_o, step_o,
//   ebreakm_o, dscratch_o.
// DM side: dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i -> dm_gnt_o, dm_rvalid_o,
//   dm_rdata_o, dm_err_o (response one cycle after grant).
// Build option: define DBG_CSR_DPC_WR_EN to allow DM writes to dpc.
module dbg_csr_bank
  import dbg_csr_pkg::*;
#(
  parameter int unsigned NUM_DSCRATCH = 2,
  parameter logic [31:0] DCSR_RESET   = DCSR_RESET_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       entry_i,
  input  logic [2:0]                 cause_i,
  input  logic [31:0]                pc_i,
  input  logic                       resume_i,
  output logic                       debug_mode_o,
  output logic [31:0]                dpc_o,
  output logic                       step_o,
  output logic                       ebreakm_o,
  output logic [32*NUM_DSCRATCH-1:0] dscratch_o,
  input  logic                       dm_req_i,
  input  logic                       dm_we_i,
  input  logic [15:0]                dm_addr_i,
  input  logic [31:0]                dm_wdata_i,
  output logic                       dm_gnt_o,
  output logic                       dm_rvalid_o,
  output logic [31:0]                dm_rdata_o,
  output logic                       dm_err_o
);

`ifdef DBG_CSR_DPC_WR_EN
  localparam bit DpcWrEn = 1'b1;
`else
  localparam bit DpcWrEn = 1'b0;
`endif

  mode_e mode_q, mode_d;
  acc_e  acc_q, acc_d;
  logic [31:0] dpc_q, dpc_d;
  logic [NUM_DSCRATCH-1:0][31:0] dscratch_q, dscratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] dcsr;

  logic        capture;
  logic        hit_dcsr, hit_dpc, hit_scr, acc_err, wr;
  int unsigned scr_idx;
  logic [31:0] acc_rdata;

  assign capture = (mode_q == ModeRun) && entry_i;

  // Mode FSM
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      ModeRun:    if (entry_i)  mode_d = ModeHalted;
      ModeHalted: if (resume_i) mode_d = ModeRun;
      default:    mode_d = ModeRun;
    endcase
  end

  // Access FSM
  always_comb begin
    acc_d = acc_q;
    unique case (acc_q)
      AccIdle: if (dm_req_i) acc_d = AccResp;
      AccResp: acc_d = AccIdle;
      default: acc_d = AccIdle;
    endcase
  end

  assign dm_gnt_o = dm_req_i && (acc_q == AccIdle);

  // Access decode, checked against the mode before any resume takes effect.
  always_comb begin
    hit_dcsr  = 1'b0;
    hit_dpc   = 1'b0;
    hit_scr   = 1'b0;
    acc_err   = 1'b0;
    acc_rdata = '0;
    scr_idx   = {31'b0, dm_addr_i[0]};
    case (dm_addr_i[11:0])
      CSR_DCSR: begin
        hit_dcsr  = 1'b1;
        acc_rdata = dcsr;
      end
      CSR_DPC: begin
        hit_dpc   = 1'b1;
        acc_rdata = dpc_q;
        if (dm_we_i && !DpcWrEn) acc_err = 1'b1;
      end
      CSR_DSCRATCH0, CSR_DSCRATCH1: begin
        hit_scr = 1'b1;
        if (scr_idx >= NUM_DSCRATCH) acc_err = 1'b1;
        for (int unsigned i = 0; i < NUM_DSCRATCH; i++) begin
          if (scr_idx == i) acc_rdata = dscratch_q[i];
        end
      end
      default: acc_err = 1'b1;
    endcase
    if (dm_addr_i[15:12] != 4'h0 || mode_q != ModeHalted) acc_err = 1'b1;
    if (acc_err || dm_we_i) acc_rdata = '0;
  end

  assign wr = dm_gnt_o && dm_we_i && !acc_err;

  always_comb begin
    dpc_d = dpc_q;
    if (capture) begin
      dpc_d = pc_i;
    end else if (wr && hit_dpc) begin
      dpc_d = dm_wdata_i;
    end
    dscratch_d = dscratch_q;
    for (int unsigned i = 0; i < NUM_DSCRATCH; i++) begin
      if (wr && hit_scr && scr_idx == i) dscratch_d[i] = dm_wdata_i;
    end
    rdata_d = dm_gnt_o ? acc_rdata : '0;
    err_d   = dm_gnt_o && acc_err;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q     <= ModeRun;
      acc_q      <= AccIdle;
      dpc_q      <= '0;
      dscratch_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      dpc_q      <= dpc_d;
      dscratch_q <= dscratch_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  dbg_dcsr_reg #(
    .DCSR_RESET (DCSR_RESET)
  ) u_dcsr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .capture_i (capture),
    .cause_i   (cause_i),
    .we_i      (wr && hit_dcsr),
    .wdata_i   (dm_wdata_i),
    .dcsr_o    (dcsr),
    .step_o    (step_o),
    .ebreakm_o (ebreakm_o)
  );

  // A reset arriving while a response is pending suppresses that response.
  assign dm_rvalid_o  = (acc_q == AccResp) && !reset_i;
  assign dm_rdata_o   = dm_rvalid_o ? rdata_q : '0;
  assign dm_err_o     = dm_rvalid_o && err_q;
  assign debug_mode_o = (mode_q == ModeHalted);
  assign dpc_o        = dpc_q;
  assign dscratch_o   = dscratch_q;

endmodule
